// File: rtl/prbs_chk.sv
// prbs_chk: 8-bit-per-word PRBS7 checker with SEARCH/LOCKED alignment FSM and saturating error counter
// Ports: clk; rstn (async active-low, release synchronised by two flops);
//        din/din_vld (received word and qualifier); clr_cnt (synchronous clear of err_cnt);
//        lock (aligned); err (one-cycle pulse per bad word while locked); err_cnt (saturating).
// Option: define PRBS_CHK_BITCNT_EN to add the number of wrong bits per bad word instead of 1.
module prbs_chk #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic {SEARCH, LOCKED} state_t;
    localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_CNT);

    // Eight steps of x^7+x^6+1 at once; bit 0 of the previous word never feeds the next one.
    function automatic logic [7:0] nxt(input logic [7:0] f);
        logic [7:0] p;
        p[0] = f[1] ^ f[2];
        p[1] = f[2] ^ f[3];
        p[2] = f[3] ^ f[4];
        p[3] = f[4] ^ f[5];
        p[4] = f[5] ^ f[6];
        p[5] = f[6] ^ f[7];
        p[6] = f[7] ^ p[0];
        p[7] = p[0] ^ p[1];
        return p;
    endfunction

`ifdef PRBS_CHK_BITCNT_EN
    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
        return n;
    endfunction
`endif

    // Assert asynchronously, release two clk edges after rstn rises.
    logic [1:0] rs;
    logic       rst_n;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rs <= '0;
        else       rs <= {rs[0], 1'b1};
    assign rst_n = rs[1];

    state_t             state_q, state_d;
    logic [7:0]         mcnt_q, mcnt_d, bcnt_q, bcnt_d;
    logic [7:0]         pred_q, pred_d, last_q, last_d;
    logic               prev_q, prev_d, err_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [7:0]         exp_w;
    logic [3:0]         inc;
    logic [CNT_W+3:0]   sum;
    logic               hit, miss;

    assign exp_w = nxt(pred_q);
    // An all-zero word never counts as a match, so an idle line cannot lock.
    assign hit   = prev_q && din != 8'h00 && din == nxt(last_q);
    assign miss  = din != exp_w;
`ifdef PRBS_CHK_BITCNT_EN
    assign inc   = popcnt(din ^ exp_w);
`else
    assign inc   = 4'd1;
`endif
    assign sum   = {4'b0, err_cnt} + {{CNT_W{1'b0}}, inc};

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        bcnt_d  = bcnt_q;
        pred_d  = pred_q;
        last_d  = last_q;
        prev_d  = prev_q;
        err_d   = 1'b0;
        cnt_d   = err_cnt;
        if (din_vld) begin
            if (state_q == SEARCH) begin
                last_d = din;
                prev_d = 1'b1;
                mcnt_d = hit ? mcnt_q + 8'd1 : 8'd0;
                if (hit && mcnt_q + 8'd1 == LOCK_C) begin
                    state_d = LOCKED;
                    pred_d  = din;
                    mcnt_d  = 8'd0;
                    bcnt_d  = 8'd0;
                end
            end else begin
                pred_d = exp_w;
                bcnt_d = miss ? bcnt_q + 8'd1 : 8'd0;
                err_d  = miss;
                if (miss)
                    cnt_d = |sum[CNT_W+3:CNT_W] ? '1 : sum[CNT_W-1:0];
                if (miss && bcnt_q + 8'd1 == UNLOCK_C) begin
                    state_d = SEARCH;
                    mcnt_d  = 8'd0;
                    bcnt_d  = 8'd0;
                    last_d  = din;
                    prev_d  = 1'b1;
                end
            end
        end
        if (clr_cnt)
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= SEARCH;
            mcnt_q  <= '0;
            bcnt_q  <= '0;
            pred_q  <= '0;
            last_q  <= '0;
            prev_q  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            bcnt_q  <= bcnt_d;
            pred_q  <= pred_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            err     <= err_d;
            err_cnt <= cnt_d;
        end

    assign lock = state_q == LOCKED;
endmodule

// File: tb/tb_prbs_chk.sv
// tb_prbs_chk: directed self-checking bench for prbs_chk (default instance plus a CNT_W=4 instance)
module tb_prbs_chk;
    logic        clk = 1'b0, rstn = 1'b1, din_vld = 1'b0, clr_cnt = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        lock, err, lock4, err4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
    int          n_chk = 0, n_bad = 0;
    int          exp_cnt;
    logic [7:0]  g;
    logic        seen;

`ifdef PRBS_CHK_BITCNT_EN
    localparam int FF_INC = 8;
`else
    localparam int FF_INC = 1;
`endif

    prbs_chk u_dut (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .lock(lock), .err(err), .err_cnt(err_cnt)
    );

    prbs_chk #(.CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .lock(lock4), .err(err4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nxt(input logic [7:0] f);
        logic [7:0] p;
        p[0] = f[1] ^ f[2];
        p[1] = f[2] ^ f[3];
        p[2] = f[3] ^ f[4];
        p[3] = f[4] ^ f[5];
        p[4] = f[5] ^ f[6];
        p[5] = f[6] ^ f[7];
        p[6] = f[7] ^ p[0];
        p[7] = p[0] ^ p[1];
        return p;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic c);
        @(negedge clk);
        din = d;
        din_vld = v;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic good();
        step(g, 1'b1, 1'b0);
        g = nxt(g);
    endtask

    task automatic bad(input logic [7:0] m);
        step(g ^ m, 1'b1, 1'b0);
        g = nxt(g);
    endtask

    initial begin
        #1 rstn = 1'b0;
        #2;
        check("rst_lock", lock, 0);
        check("rst_err", err, 0);
        check("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) step(8'h00, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (100) begin
            step(8'h00, 1'b1, 1'b0);
            seen |= lock;
        end
        check("zero_lock", seen, 0);
        g = 8'h08;
        good();
        check("gen_first", g, 8'h86);
        repeat (15) good();
        check("lock_16", lock, 0);
        good();
        check("lock_17", lock, 1);
        check("lock_cnt", err_cnt, 0);
        check("lock_sat", lock4, 1);
        seen = 1'b0;
        repeat (6) begin
            step(8'hA5, 1'b0, 1'b0);
            seen |= err;
            good();
            seen |= err;
        end
        check("gap_err", seen, 0);
        check("gap_lock", lock, 1);
        bad(8'h01);
        check("e1_err", err, 1);
        check("e1_cnt", err_cnt, 1);
        check("e1_lock", lock, 1);
        check("e1_sat_err", err4, 1);
        check("e1_sat_cnt", err_cnt4, 1);
        good();
        check("e1_pulse", err, 0);
        bad(8'hFF);
        exp_cnt = 1 + FF_INC;
        check("ff_cnt", err_cnt, exp_cnt);
        check("ff_sat", err_cnt4, exp_cnt);
        good();
        repeat (20) begin
            bad(8'h01);
            good();
        end
        exp_cnt += 20;
        check("sat_main", err_cnt, exp_cnt);
        check("sat_cnt", err_cnt4, 15);
        check("sat_lock", lock, 1);
        step(g ^ 8'h01, 1'b1, 1'b1);
        g = nxt(g);
        check("clr_cnt", err_cnt, 0);
        check("clr_err", err, 1);
        check("clr_sat", err_cnt4, 0);
        good();
        repeat (3) bad(8'h10);
        check("unl_3", lock, 1);
        bad(8'h10);
        check("unl_4", lock, 0);
        check("unl_cnt", err_cnt, 4);
        seen = 1'b0;
        repeat (3) begin
            step(8'h55, 1'b1, 1'b0);
            seen |= err;
        end
        check("srch_err", seen, 0);
        check("srch_cnt", err_cnt, 4);
        step(8'h00, 1'b1, 1'b0);
        repeat (16) good();
        check("relock_16", lock, 0);
        good();
        check("relock_17", lock, 1);
        bad(8'h01);
        check("pre_err", err, 1);
        check("pre_cnt", err_cnt, 5);
        #2 rstn = 1'b0;
        #1;
        check("ar_lock", lock, 0);
        check("ar_err", err, 0);
        check("ar_cnt", err_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) step(8'h00, 1'b0, 1'b0);
        g = 8'h08;
        repeat (16) good();
        check("rr_16", lock, 0);
        good();
        check("rr_17", lock, 1);
        check("rr_cnt", err_cnt, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/prbs_chk.md
PRBS_CHK -- requirements
Module: prbs_chk

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive matching words needed to declare lock; legal range 2..255.
REQ-002 Parameter UNLOCK_CNT, default 4: consecutive mismatching words that drop lock; legal range 1..255.
REQ-003 Parameter CNT_W, default 16: width of err_cnt.
REQ-004 clk  input  1  sole clock; all logic is rising-edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 din  input  8  received PRBS word, sampled when din_vld=1.
REQ-007 din_vld  input  1  din qualifier; words with din_vld=0 are ignored.
REQ-008 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 lock  output  1  1 = checker is aligned to the incoming sequence.
REQ-010 err  output  1  one-cycle pulse per mismatching word while locked.
REQ-011 err_cnt  output  CNT_W  saturating error counter.

Function
REQ-012 Word recurrence next(f), with f = previous word and p = next word, SHALL be:
- p0=f1^f2, p1=f2^f3, p2=f3^f4, p3=f4^f5, p4=f5^f6, p5=f6^f7, p6=f7^p0, p7=p0^p1.
- Example: next(0x08)=0x86.
REQ-013 FSM states SHALL be SEARCH and LOCKED; the reset state is SEARCH.
REQ-014 SEARCH compare rule, for each valid word:
- Compare din with next(last valid din).
- Match: increment the match counter.
- Mismatch, or no prior valid word since entering SEARCH: zero the match counter.
- In all cases, store din as the new last valid din.
REQ-015 In SEARCH, din=0x00 SHALL be treated as a mismatch, so the checker never locks on an idle all-zero line.
REQ-016 When the match counter reaches LOCK_CNT, the FSM SHALL:
- enter LOCKED;
- load the predictor with that din;
- assert lock on the next rising edge.
REQ-017 LOCKED predictor: for each valid word, expected = next(predictor) and the predictor loads expected; it is never reseeded from din while LOCKED.
REQ-018 LOCKED compare rule, for each valid word:
- din != expected: err=1 for one cycle (the cycle after the word), err_cnt is updated, and the bad counter increments.
- din == expected: the bad counter clears.
REQ-019 When the bad counter reaches UNLOCK_CNT, the FSM SHALL:
- enter SEARCH;
- deassert lock on the next edge;
- zero the match counter;
- seed last valid din with the current din.
REQ-020 Cycles with din_vld=0 SHALL NOT change state, counters, predictor or err_cnt; err=0 on those cycles.
REQ-021 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 clr_cnt=1 SHALL set err_cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-023 err_cnt SHALL NOT count in SEARCH.
REQ-024 Latency: lock, err and err_cnt SHALL be registered, updating one cycle after the qualifying din sample.

Reset
REQ-025 rstn low SHALL immediately force the following, regardless of clk:
- lock=0, err=0, err_cnt=0;
- FSM=SEARCH;
- all counters, predictor and last valid din = 0.
REQ-026 Reset release SHALL be synchronised through two flops clocked by clk; logic leaves reset on the second rising edge after rstn rises.

Configuration
REQ-027 With macro PRBS_CHK_BITCNT_EN defined, each mismatching word SHALL add popcount(din ^ expected) to err_cnt, saturating at the maximum; without it, each mismatching word SHALL add 1.

Verification
REQ-028 Lock acquisition:
- Stimulus: reset released, continuous valid stream from the generator seeded 0x08 (0x08, 0x86, ...).
- Response: lock=1 one cycle after the 17th word; err_cnt=0.
REQ-029 Single-bit error while locked:
- Stimulus: one word with bit 0 inverted.
- Response: err high for exactly one cycle, err_cnt=1, lock stays 1.
- Stimulus: one word XOR 0xFF.
- Response: err_cnt +8 with PRBS_CHK_BITCNT_EN, +1 without.
REQ-030 Loss of lock:
- Stimulus: 4 consecutive corrupted words while locked.
- Response: lock=0 one cycle after the 4th; later errors do not increment err_cnt.
- Stimulus: stream restored.
- Response: relock after LOCK_CNT matches.
REQ-031 Valid gaps and zeros:
- Stimulus: din_vld toggled 1/0 on a correct stream.
- Response: no err, lock retained.
- Stimulus: all-zero din for 100 words in SEARCH.
- Response: lock stays 0.
REQ-032 Clear and saturation:
- Stimulus: CNT_W=4 with 20 word errors.
- Response: err_cnt holds at 15.
- Stimulus: clr_cnt=1 coincident with an error.
- Response: err_cnt=0.
REQ-033 Reset while locked:
- Stimulus: rstn pulsed low mid-stream.
- Response: lock, err and err_cnt go to 0 asynchronously; relock after 2 sync cycles + 17 words.
